agc_mem_seq: RTL and testbench
==============================

AGC_MEM_SEQ -- requirements
Module: agc_mem_seq

Interface
REQ-001 Parameters: AGC_ADDR_W, default 12, AGC word address width; DATA_W, default 15, AGC data word width; MEM_AW, default 32, flat memory address width.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer accepts a request this cycle.
REQ-006 req_cmd  input  2  operation: 00 read, 01 write, 10 set EBANK, 11 reserved.
REQ-007 req_addr  input  AGC_ADDR_W  AGC erasable word address.
REQ-008 req_wdata  input  DATA_W  write data; req_wdata[1:0] is the new EBANK value for cmd 10.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_rdata  output  DATA_W  read data, zero for non-read commands.
REQ-012 rsp_err  output  1  address out of range, reserved cmd, or parity error.
REQ-013 mem_addr  output  MEM_AW  flat address to the data memory.
REQ-014 mem_wdata  output  32  memory write word.
REQ-015 mem_we  output  1  memory write enable, sampled by the memory on the rising clk edge.
REQ-016 mem_rdata  input  32  combinational memory read word for mem_addr.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: transfer on req_valid&&req_ready, and on rsp_valid&&rsp_ready; rsp_* SHALL hold stable while rsp_valid&&!rsp_ready.
REQ-019 Address map: req_addr<0x300 gives flat=req_addr; 0x300..0x3FF gives flat={ebank[1:0],req_addr[7:0]}; >=0x400 is out of range.
REQ-020 IDLE, valid read/write accepted -> ACCESS; mem_addr/mem_wdata registered, and mem_we=1 for exactly the ACCESS cycle on writes only.
REQ-021 ACCESS: read captures mem_rdata[DATA_W-1:0] into rsp_rdata at the edge leaving ACCESS -> RESP; response latency is 2 cycles from acceptance.
REQ-022 Out-of-range address or reserved cmd -> RESP directly, rsp_err=1, no memory access, and latency 1.
REQ-023 cmd 10: ebank<=req_wdata[1:0] at acceptance -> RESP directly with rsp_err=0, latency 1, and no memory access.
REQ-024 A 0x300..0x3FF access accepted in the cycle after a set-EBANK SHALL use the new EBANK value.
REQ-025 RESP: rsp_valid=1; on rsp_ready -> IDLE, with req_ready rising the following cycle (no back-to-back accept from RESP).
REQ-026 mem_wdata bits 31:16 SHALL be 0; bit 15 is parity when PARITY_EN is defined, else 0.

Reset
REQ-027 rst_n low asynchronously forces state=IDLE, ebank=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, and rsp_err=0.
REQ-028 Reset during ACCESS SHALL drop mem_we immediately, so no write completes; a pending response is discarded.

Configuration
REQ-029 Macro AGC_MEM_PARITY_EN defined: write sets mem_wdata[15]=~^data (odd parity over 16 bits); read with odd-parity failure sets rsp_err=1 and still returns the data.
REQ-030 AGC_MEM_PARITY_EN undefined: mem_wdata[15]=0, mem_rdata[15] is ignored, and there is no parity error.

Structure
REQ-031 Shared package agc_pkg SHALL hold the cmd encoding constants, the state enum typedef, the address map bounds 0x300 and 0x400, and DATA_W.
REQ-032 One sub-module agc_addr_xlat SHALL be combinational: req_addr plus ebank -> flat address plus out_of_range flag.

Verification
REQ-033 Write addr 0x012 data 0x1234, rsp_ready=1: mem_we pulses 1 cycle with mem_addr=0x012; rsp_valid appears 2 cycles after accept, err=0.
REQ-034 Set EBANK=2, then read 0x345: mem_addr=0x245; rsp_rdata equals the word previously written at flat 0x245.
REQ-035 Read 0x400: rsp_valid arrives after 1 cycle, err=1, mem_we never asserted, and mem_addr is unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles: rsp_* stable, req_ready=0 throughout, and new req_valid is ignored.
REQ-037 Assert rst_n=0 mid-ACCESS of a write: mem_we falls at once, the target word is unchanged, and all outputs return to their reset values.
REQ-038 With AGC_MEM_PARITY_EN: write 0x0001 gives mem_wdata=0x0000_0001; a forced mem_rdata=0x0000_8001 read returns rsp_err=1 and rdata=0x0001.

Source files
------------

// File: rtl/agc_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg -- shared definitions for the AGC erasable-memory sequencer.
//   Command encodings, sequencer state type, erasable address-map bounds,
//   the AGC data word width and the parity helper used on the memory word.
//   Optional feature macro used by the sequencer: AGC_MEM_PARITY_EN.
// -----------------------------------------------------------------------------
package agc_pkg;

  localparam int unsigned DATA_W = 15;

  // Request command field
  localparam logic [1:0] CMD_READ      = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_EBANK = 2'b10;
  localparam logic [1:0] CMD_RSVD      = 2'b11;

  // Erasable address map: fixed-erasable below EBANK_BASE, banked window
  // from EBANK_BASE up to ADDR_LIMIT, nothing at or above ADDR_LIMIT.
  localparam int unsigned EBANK_BASE = 32'h0000_0300;
  localparam int unsigned ADDR_LIMIT = 32'h0000_0400;

  // Position of the parity bit inside the 32-bit memory word
  localparam int unsigned PARITY_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } agc_state_e;

  // Bit that makes {parity, data} carry an odd number of ones.
  function automatic logic odd_parity_bit(input logic [14:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/agc_addr_xlat.sv
// -----------------------------------------------------------------------------
// agc_addr_xlat -- combinational AGC erasable address translation.
//   addr          : AGC erasable word address
//   ebank         : current erasable bank register
//   flat          : flat data-memory address (zero when out of range)
//   out_of_range  : addr lies at or above the end of erasable memory
// -----------------------------------------------------------------------------
module agc_addr_xlat #(
  parameter int unsigned AGC_ADDR_W = 12,
  parameter int unsigned MEM_AW     = 32
) (
  input  logic [AGC_ADDR_W-1:0] addr,
  input  logic [1:0]            ebank,
  output logic [MEM_AW-1:0]     flat,
  output logic                  out_of_range
);
  import agc_pkg::*;

  localparam logic [AGC_ADDR_W-1:0] BANK_LO = AGC_ADDR_W'(EBANK_BASE);
  localparam logic [AGC_ADDR_W-1:0] LIMIT   = AGC_ADDR_W'(ADDR_LIMIT);

  always_comb begin
    flat         = '0;
    out_of_range = 1'b0;
    if (addr >= LIMIT) begin
      out_of_range = 1'b1;
    end else if (addr >= BANK_LO) begin
      // Banked window: 256-word bank selected by ebank
      flat = MEM_AW'({ebank, addr[7:0]});
    end else begin
      flat = MEM_AW'(addr);
    end
  end

endmodule

// File: rtl/agc_mem_seq.sv
// -----------------------------------------------------------------------------
// agc_mem_seq -- request/response sequencer between AGC erasable accesses and
// a flat 32-bit data memory.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_cmd/addr/wdata     : 00 read, 01 write, 10 set EBANK, 11 reserved
//   rsp_valid/rsp_ready    : response handshake, response held until taken
//   rsp_rdata/rsp_err      : read data (zero otherwise), error flag
//   mem_addr/wdata/we      : registered memory request, we for one cycle
//   mem_rdata              : combinational memory read word
// Macro AGC_MEM_PARITY_EN: odd parity in bit 15 of the memory word is
// generated on writes and checked on reads.
// -----------------------------------------------------------------------------
module agc_mem_seq #(
  parameter int unsigned AGC_ADDR_W = 12,
  parameter int unsigned DATA_W     = agc_pkg::DATA_W,
  parameter int unsigned MEM_AW     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [AGC_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);
  import agc_pkg::*;

  agc_state_e          state_q, state_d;
  logic [1:0]          ebank_q, ebank_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [MEM_AW-1:0]   xlat_flat;
  logic                xlat_oor;
  logic [14:0]         wr_data15;
  logic                wr_par;
  logic                rd_perr;
  logic [31:0]         wr_word;
  logic                unused_rdata;

  agc_addr_xlat #(
    .AGC_ADDR_W (AGC_ADDR_W),
    .MEM_AW     (MEM_AW)
  ) u_xlat (
    .addr         (req_addr),
    .ebank        (ebank_q),
    .flat         (xlat_flat),
    .out_of_range (xlat_oor)
  );

  assign wr_data15 = 15'(req_wdata);

`ifdef AGC_MEM_PARITY_EN
  assign wr_par  = odd_parity_bit(wr_data15);
  // A stored word with an even number of ones has lost its parity
  assign rd_perr = ~(^mem_rdata[PARITY_BIT:0]);
`else
  assign wr_par  = 1'b0;
  assign rd_perr = 1'b0;
`endif

  assign unused_rdata = ^mem_rdata[31:DATA_W];
  assign wr_word      = {16'h0000, wr_par, wr_data15};

  always_comb begin
    state_d     = state_q;
    ebank_d     = ebank_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (req_cmd)
            CMD_READ, CMD_WRITE: begin
              if (xlat_oor) begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
              end else begin
                state_d     = ST_ACCESS;
                mem_addr_d  = xlat_flat;
                mem_wdata_d = wr_word;
                mem_we_d    = (req_cmd == CMD_WRITE);
              end
            end
            CMD_SET_EBANK: begin
              ebank_d     = req_wdata[1:0];
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = '0;
              rsp_err_d   = 1'b0;
            end
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = '0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_ACCESS: begin
        // mem_we_q is high in ACCESS only for writes, so it doubles as the
        // read/write flag of the access in flight.
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        if (mem_we_q) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_rdata_d = mem_rdata[DATA_W-1:0];
          rsp_err_d   = rd_perr;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ebank_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ebank_q     <= ebank_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_agc_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_agc_mem_seq -- self-checking bench for agc_mem_seq.
//   Directed scenarios followed by random transactions, each response checked
//   against a reference model of the AGC erasable map, EBANK and memory.
// -----------------------------------------------------------------------------
module tb_agc_mem_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [11:0] req_addr;
  logic [14:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [14:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  agc_mem_seq #(
    .AGC_ADDR_W (12),
    .DATA_W     (15),
    .MEM_AW     (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory seen by the DUT
  logic [31:0] phys_mem [0:1023];
  logic        force_en;
  logic [31:0] force_word;

  assign mem_rdata = force_en ? force_word : phys_mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_we) phys_mem[mem_addr[9:0]] <= mem_wdata;
  end

  // Reference model
  int unsigned ref_mem [0:1023];
  int unsigned ref_ebank;
  int unsigned ref_last_addr;
  bit          par_on;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request, response wait, optional stall, take.
  task automatic xact(input int unsigned cmd, input int unsigned addr, input int unsigned wd,
                      input int unsigned hold, input bit use_force, input int unsigned fword);
    int unsigned exp_lat, exp_we, exp_err, exp_rdata, flat, word, stored;
    int unsigned lat, we_cnt;
    bit access;
    access = 0; exp_we = 0; exp_err = 0; exp_rdata = 0; flat = 0; word = 0; exp_lat = 1;
    if (cmd == 3) begin
      exp_err = 1;
    end else if (cmd == 2) begin
      exp_err = 0;
    end else if (addr >= 1024) begin
      exp_err = 1;
    end else begin
      access  = 1;
      exp_lat = 2;
      flat    = (addr < 768) ? addr : ref_ebank * 256 + addr % 256;
      word    = wd + ((par_on && ($countones(wd) % 2 == 0)) ? 32768 : 0);
      if (cmd == 1) begin
        exp_we = 1;
      end else begin
        stored    = use_force ? fword : ref_mem[flat];
        exp_rdata = stored % 32768;
        exp_err   = (par_on && ($countones(stored % 65536) % 2 == 0)) ? 1 : 0;
      end
    end
    if (access) ref_last_addr = flat;

    force_en   = use_force;
    force_word = fword;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd[1:0];
    req_addr  = addr[11:0];
    req_wdata = wd[14:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    req_wdata = 15'($urandom);

    lat = 1; we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_we === 1'b1) begin
        we_cnt++;
        check("we_addr", mem_addr, flat);
        check("we_data", mem_wdata, word);
      end
      if (rsp_valid === 1'b1) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("latency", lat, exp_lat);
    check("we_cycles", we_cnt, exp_we);
    check("mem_addr", mem_addr, ref_last_addr);
    check("rsp_err", {31'b0, rsp_err}, exp_err);
    check("rsp_rdata", {17'b0, rsp_rdata}, exp_rdata);
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);

    // Stall the consumer while offering a competing request
    for (int h = 0; h < int'(hold); h++) begin
      req_valid = 1'b1;
      req_cmd   = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_err", {31'b0, rsp_err}, exp_err);
      check("hold_rdata", {17'b0, rsp_rdata}, exp_rdata);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
      check("hold_we", {31'b0, mem_we}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    force_en  = 1'b0;
    check("taken_valid", {31'b0, rsp_valid}, 32'd0);
    check("taken_ready", {31'b0, req_ready}, 32'd1);

    if (access && cmd == 1) ref_mem[flat] = word;
    if (cmd == 2) ref_ebank = wd % 4;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'b0, mem_we},    32'd0);
    check({tag, "_addr"},  mem_addr,           32'd0);
    check({tag, "_wdata"}, mem_wdata,          32'd0);
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rdata"}, {17'b0, rsp_rdata}, 32'd0);
    check({tag, "_err"},   {31'b0, rsp_err},   32'd0);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, w, r, c;
    n_vec = 0; n_err = 0;
`ifdef AGC_MEM_PARITY_EN
    par_on = 1'b1;
`else
    par_on = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = '0;
      ref_mem[i]  = 0;
    end
    ref_ebank = 0; ref_last_addr = 0;
    force_en = 1'b0; force_word = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Plain write, then read it back
    xact(1, 'h012, 'h1234, 0, 0, 0);
    xact(0, 'h012, 0, 0, 0, 0);
    // Banked access after EBANK change
    xact(1, 'h245, 'h2A5C, 0, 0, 0);
    xact(2, 0, 2, 0, 0, 0);
    xact(0, 'h345, 0, 0, 0, 0);
    // Out-of-range read and reserved command
    xact(0, 'h400, 0, 0, 0, 0);
    xact(3, 'h010, 0, 0, 0, 0);
    // Long consumer stall
    xact(0, 'h245, 0, 5, 0, 0);
    // Parity-bearing write and forced-corrupt read word
    xact(1, 'h001, 'h0001, 0, 0, 0);
    xact(0, 'h010, 0, 0, 1, 'h0000_8001);

    // Reset in the middle of a write's ACCESS cycle
    a = $urandom_range(0, 767);
    w = $urandom_range(0, 32767);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b01; req_addr = a[11:0]; req_wdata = w[14:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_pre_we", {31'b0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_ebank = 0; ref_last_addr = 0;
    check("rst_target_word", phys_mem[a], ref_mem[a]);
    xact(0, 'h300 + (a % 256), 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      r = $urandom_range(0, 3);
      a = (r < 2) ? $urandom_range(0, 'h2FF) :
          (r == 2) ? $urandom_range('h300, 'h3FF) : $urandom_range('h400, 'hFFF);
      w = $urandom_range(0, 32767);
      xact(c, a, w, $urandom_range(0, 3), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
